// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the 8-digit multiplexed time display.
// Segment patterns are active-low, bit0 = CA .. bit6 = CG.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic VIEW_HMS = 1'b0;
    localparam logic VIEW_MSM = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Nibbles 10-15 are not valid BCD and render as a dash.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/seg7_time_scanner_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = GLYPH[bcd];

endmodule

// File: rtl/seg7_time_scanner.sv
// Scans a frame-stable snapshot of BCD time onto an 8-digit common-anode display,
// with an all-off gap before every digit and a blinking digit while a field is being set.
module seg7_time_scanner
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = 100_000,
    parameter int BLANK_TICKS = 1_000,
    parameter int BLINK_TICKS = 25_000_000
) (
    input  logic        clk_in,
    input  logic        resetn,
    input  logic [7:0]  Hours_i,
    input  logic [7:0]  Minutes_i,
    input  logic [7:0]  Seconds_i,
    input  logic [11:0] milli_i,
    input  logic [5:0]  set_i,
    input  logic        view_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int TICK_MAX = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX);
    localparam int BLINK_W  = $clog2(BLINK_TICKS);

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [2:0]          idx;
    logic                last_tick;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_ph;
    logic [5:0]          set_prev;
    logic                first_q;

    logic [7:0]          hours_q, minutes_q, seconds_q;
    logic [11:0]         milli_q;
    logic                view_q;

    logic                view_eff;
    logic [3:0]          nibble;
    logic                dp_lit;
    logic                blank_digit;
    logic [6:0]          glyph;
    logic [7:0]          blink_mask;
    logic                blink_hit;
    logic [7:0]          an_nxt;
    logic [6:0]          seg_nxt;
    logic                dp_nxt;

    bcd_to_seg7 u_dec (
        .bcd (nibble),
        .seg (glyph)
    );

    // Any set code forces the full HH.MM.SS view so the field being edited is visible.
    assign view_eff   = (set_i != 6'd0) ? VIEW_HMS : view_q;
    assign blink_mask = {set_i, 2'b00};
    assign blink_hit  = $onehot(set_i) && blink_ph && blink_mask[idx];

    always_comb begin
        nibble      = 4'h0;
        dp_lit      = 1'b0;
        blank_digit = 1'b0;
        if (view_eff == VIEW_HMS) begin
            case (idx)
                3'd7:    nibble = hours_q[7:4];
                3'd6:    nibble = hours_q[3:0];
                3'd5:    nibble = minutes_q[7:4];
                3'd4:    nibble = minutes_q[3:0];
                3'd3:    nibble = seconds_q[7:4];
                3'd2:    nibble = seconds_q[3:0];
                3'd1:    nibble = milli_q[11:8];
                default: nibble = milli_q[7:4];
            endcase
            dp_lit = (idx == 3'd6) || (idx == 3'd4) || (idx == 3'd2);
        end else begin
            case (idx)
                3'd7:    blank_digit = 1'b1;
                3'd6:    nibble = minutes_q[7:4];
                3'd5:    nibble = minutes_q[3:0];
                3'd4:    nibble = seconds_q[7:4];
                3'd3:    nibble = seconds_q[3:0];
                3'd2:    nibble = milli_q[11:8];
                3'd1:    nibble = milli_q[7:4];
                default: nibble = milli_q[3:0];
            endcase
            dp_lit = (idx == 3'd5) || (idx == 3'd3);
        end
    end

    always_comb begin
        state_nxt = state;
        last_tick = 1'b0;
        an_nxt    = an_o;
        seg_nxt   = seg_o;
        dp_nxt    = dp_o;
        case (state)
            BLANK: if (tick_cnt == TICK_W'(BLANK_TICKS - 1)) begin
                last_tick = 1'b1;
                state_nxt = DRIVE;
            end
            default: if (tick_cnt == TICK_W'(DIGIT_TICKS - 1)) begin
                last_tick = 1'b1;
                state_nxt = BLANK;
            end
        endcase
        // Digit content and blink decision are fixed at slot entry and held for the slot.
        if (state == BLANK && state_nxt == DRIVE) begin
            an_nxt  = blink_hit ? 8'hFF : ~(8'b1 << idx);
            seg_nxt = blank_digit ? SEG_BLANK : glyph;
            dp_nxt  = ~dp_lit;
        end else if (state_nxt == BLANK) begin
            an_nxt  = 8'hFF;
            seg_nxt = SEG_BLANK;
            dp_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            state     <= BLANK;
            tick_cnt  <= '0;
            idx       <= 3'd0;
            an_o      <= 8'hFF;
            seg_o     <= SEG_BLANK;
            dp_o      <= 1'b1;
            first_q   <= 1'b1;
            hours_q   <= 8'h00;
            minutes_q <= 8'h00;
            seconds_q <= 8'h00;
            milli_q   <= 12'h000;
            view_q    <= VIEW_HMS;
        end else begin
            state    <= state_nxt;
            tick_cnt <= last_tick ? '0 : tick_cnt + TICK_W'(1);
            an_o     <= an_nxt;
            seg_o    <= seg_nxt;
            dp_o     <= dp_nxt;
            first_q  <= 1'b0;
            if (state == DRIVE && last_tick)
                idx <= idx + 3'd1;
            if (first_q || (state == DRIVE && last_tick && idx == 3'd7)) begin
                hours_q   <= Hours_i;
                minutes_q <= Minutes_i;
                seconds_q <= Seconds_i;
                milli_q   <= milli_i;
                view_q    <= view_i;
            end
        end
    end

    // A set-code change restarts the blink phase so the newly selected digit shows first.
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            set_prev  <= 6'd0;
        end else begin
            set_prev <= set_i;
            if (set_i != set_prev) begin
                blink_cnt <= '0;
                blink_ph  <= 1'b0;
            end else if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_time_scanner.sv
// Bench for seg7_time_scanner: directed scenarios followed by random input traffic,
// every cycle compared against a frame-position model of the display.
module tb_seg7_time_scanner;

    localparam int DT    = 4;
    localparam int BT    = 2;
    localparam int KT    = 16;
    localparam int SLOT  = DT + BT;
    localparam int FRAME = 8 * SLOT;

    logic        clk_in = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  hours = 8'h00, minutes = 8'h00, seconds = 8'h00;
    logic [11:0] milli = 12'h000;
    logic [5:0]  set_code = 6'd0;
    logic        view = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    seg7_time_scanner #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT),
        .BLINK_TICKS (KT)
    ) dut (
        .clk_in    (clk_in),
        .resetn    (resetn),
        .Hours_i   (hours),
        .Minutes_i (minutes),
        .Seconds_i (seconds),
        .milli_i   (milli),
        .set_i     (set_code),
        .view_i    (view),
        .an_o      (an),
        .seg_o     (seg),
        .dp_o      (dp)
    );

    // Model: c = cycles since reset release, g = global edge count.
    int          c = 0, g = 0, last_clr = 0, e_ph = 0;
    logic [5:0]  sprev = 6'd0, e_set = 6'd0;
    logic [7:0]  sh = 8'h00, sm = 8'h00, ss = 8'h00;
    logic [11:0] sms = 12'h000;
    logic        sv = 1'b0;

    // Active-high gfedcba glyphs; 10-15 are a dash (segment g only).
    logic [6:0] glyph_hi [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic [5:0] codes [9] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'b000011, 6'b100001};

    task automatic step();
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp, v, blank_d, dp_d;
        logic [31:0] word;
        logic [3:0]  nib;
        int          p, k;
        @(posedge clk_in);
        if (!resetn) begin
            c = 0; sh = 0; sm = 0; ss = 0; sms = 0; sv = 0;
            sprev = 6'd0; last_clr = g;
        end else begin
            if (c % SLOT == BT - 1) begin
                e_set = set_code;
                e_ph  = ((g - 1 - last_clr) / KT) % 2;
            end
            if (c == 0 || c % FRAME == FRAME - 1) begin
                sh = hours; sm = minutes; ss = seconds; sms = milli; sv = view;
            end
            c++;
            if (set_code != sprev) begin
                last_clr = g;
                sprev = set_code;
            end
        end
        g++;
        @(negedge clk_in);
        p = c % FRAME;
        exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
        if (p % SLOT >= BT) begin
            k = p / SLOT;
            v = (e_set != 6'd0) ? 1'b0 : sv;
            if (!v) begin
                word = {sh, sm, ss, sms[11:4]};
                blank_d = 1'b0;
                dp_d = (k == 6) || (k == 4) || (k == 2);
            end else begin
                word = {4'h0, sm, ss, sms};
                blank_d = (k == 7);
                dp_d = (k == 5) || (k == 3);
            end
            nib = word[4*k +: 4];
            exp_seg = blank_d ? 7'h7F : ~glyph_hi[nib];
            exp_dp  = ~dp_d;
            exp_an  = ~(8'd1 << k);
            if ($countones(e_set) == 1 && e_ph == 1 && k >= 2 && e_set[k-2])
                exp_an = 8'hFF;
        end
        n_assert++;
        assert (an === exp_an) else begin
            n_fail++;
            $error("FAIL an cycle=%0d observed=%h expected=%h", c, an, exp_an);
        end
        n_assert++;
        assert ({seg, dp} === {exp_seg, exp_dp}) else begin
            n_fail++;
            $error("FAIL seg_dp cycle=%0d observed=%h/%b expected=%h/%b", c, seg, dp, exp_seg, exp_dp);
        end
    endtask

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        while (c % FRAME != target && n <= FRAME) begin
            step();
            n++;
        end
        if (c % FRAME != target) begin
            n_fail++;
            $display("FAIL wait_pos observed=%0d expected=%0d", c % FRAME, target);
        end
    endtask

    initial begin
        repeat (3) step();
        resetn = 1'b1;
        hours = 8'h12; minutes = 8'h34; seconds = 8'h56; milli = 12'h789;
        repeat (2 * FRAME) step();
        view = 1'b1;
        repeat (2 * FRAME) step();
        view = 1'b0;
        wait_pos(3 * FRAME / 4 - 9);
        seconds = 8'h57;
        repeat (2 * FRAME) step();
        set_code = 6'b000100;
        repeat (4 * FRAME) step();
        set_code = 6'b001000;
        repeat (4 * FRAME) step();
        set_code = 6'd0;
        hours = 8'h3F;
        repeat (FRAME) step();
        set_code = 6'b000011;
        view = 1'b1;
        repeat (2 * FRAME) step();
        set_code = 6'd0;
        wait_pos(3 * SLOT + BT + 1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        repeat (2 * FRAME) step();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                hours   = 8'($urandom);
                minutes = 8'($urandom);
                seconds = 8'($urandom);
                milli   = 12'($urandom);
            end
            if ($urandom_range(0, 149) == 0) set_code = codes[$urandom_range(0, 8)];
            if ($urandom_range(0, 99) == 0) view = ~view;
            resetn = ($urandom_range(0, 599) != 0);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
